// File: rtl/pio_out_pkg.sv
// Register map, CTRL field positions and per-channel write request for pio_out_multi.
package pio_out_pkg;

  localparam logic [1:0] REG_DATA   = 2'd0;
  localparam logic [1:0] REG_OUTSET = 2'd1;
  localparam logic [1:0] REG_OUTCLR = 2'd2;
  localparam logic [1:0] REG_CTRL   = 2'd3;

  localparam int BLINK_EN_BIT = 0;
  localparam int PERIOD_LSB   = 8;
  localparam int PERIOD_MSB   = 15;
  localparam int COMMIT_BIT   = 31;

  typedef struct packed {
    logic        we;
    logic [1:0]  regsel;
    logic [31:0] wdata;
  } ch_req_t;

  // A programmed period of 0 blinks as fast as period 1.
  function automatic logic [7:0] eff_period(input logic [7:0] p);
    return (p == 8'd0) ? 8'd1 : p;
  endfunction

endpackage

// File: rtl/pio_out_channel.sv
// One output channel: data (and shadow with PIO_OUT_MULTI_COMMIT_EN), CTRL fields,
// blink counter/phase and the output mux.
module pio_out_channel
  import pio_out_pkg::*;
#(
  parameter int CH_WIDTH = 14
) (
  input  logic                clk,
  input  logic                reset_n,
  input  ch_req_t             req,
  input  logic                commit,
  input  logic                tick,
  output logic [CH_WIDTH-1:0] data_rd,
  output logic [31:0]         ctrl_rd,
  output logic [CH_WIDTH-1:0] out
);

  logic [CH_WIDTH-1:0] data_q, wval;
  logic                ctrl_wr;
  logic                blink_en_q, phase_q;
  logic [7:0]          period_q, cnt_q;
  logic                unused_w;

  assign wval     = req.wdata[CH_WIDTH-1:0];
  assign unused_w = &{1'b0, req.wdata, commit};

`ifdef PIO_OUT_MULTI_COMMIT_EN
  logic [CH_WIDTH-1:0] shadow_q;

  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) shadow_q <= '0;
    else if (req.we)
      case (req.regsel)
        REG_DATA:   shadow_q <= wval;
        REG_OUTSET: shadow_q <= shadow_q | wval;
        REG_OUTCLR: shadow_q <= shadow_q & ~wval;
        default: ;
      endcase

  // Commit is broadcast by the top so every channel flips on the same edge.
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n)    data_q <= '0;
    else if (commit) data_q <= shadow_q;

  assign data_rd = shadow_q;
  assign ctrl_wr = req.we && (req.regsel == REG_CTRL) && !req.wdata[COMMIT_BIT];
`else
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) data_q <= '0;
    else if (req.we)
      case (req.regsel)
        REG_DATA:   data_q <= wval;
        REG_OUTSET: data_q <= data_q | wval;
        REG_OUTCLR: data_q <= data_q & ~wval;
        default: ;
      endcase

  assign data_rd = data_q;
  assign ctrl_wr = req.we && (req.regsel == REG_CTRL);
`endif

  // A CTRL write restarts the blink cycle and wins over a coincident tick.
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      blink_en_q <= 1'b0;
      period_q   <= '0;
      cnt_q      <= '0;
      phase_q    <= 1'b0;
    end else if (ctrl_wr) begin
      blink_en_q <= req.wdata[BLINK_EN_BIT];
      period_q   <= req.wdata[PERIOD_MSB:PERIOD_LSB];
      cnt_q      <= '0;
      phase_q    <= 1'b0;
    end else if (tick && blink_en_q) begin
      if (cnt_q == eff_period(period_q) - 8'd1) begin
        cnt_q   <= '0;
        phase_q <= ~phase_q;
      end else begin
        cnt_q <= cnt_q + 8'd1;
      end
    end

  assign ctrl_rd = {16'b0, period_q, 7'b0, blink_en_q};
  assign out     = (blink_en_q && phase_q) ? '0 : data_q;

endmodule

// File: rtl/pio_out_multi.sv
// Multi-channel Avalon-MM output PIO with set/clear access and hardware blink.
// Define PIO_OUT_MULTI_COMMIT_EN for shadowed data with a global commit via CTRL[31].
module pio_out_multi
  import pio_out_pkg::*;
#(
  parameter  int CH_COUNT = 4,
  parameter  int CH_WIDTH = 14,
  parameter  int PRESCALE = 50000,
  localparam int ADDR_W   = $clog2(CH_COUNT) + 2
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic [ADDR_W-1:0]            address,
  input  logic                         chipselect,
  input  logic                         write_n,
  input  logic [31:0]                  writedata,
  output logic [31:0]                  readdata,
  output logic [CH_COUNT*CH_WIDTH-1:0] out_port
);

  localparam int PS_W = $clog2(PRESCALE);

  logic [ADDR_W-1:0] ch_idx;
  logic [1:0]        regsel;
  logic              ch_ok, wr_stb, commit, tick;
  logic [PS_W-1:0]   ps_q;

  logic [CH_COUNT-1:0][CH_WIDTH-1:0] data_rd;
  logic [CH_COUNT-1:0][31:0]         ctrl_rd;
  logic [CH_COUNT-1:0][CH_WIDTH-1:0] ch_out;

  assign ch_idx = address >> 2;
  assign regsel = address[1:0];
  assign ch_ok  = ch_idx < ADDR_W'(CH_COUNT);
  assign wr_stb = chipselect && !write_n;

`ifdef PIO_OUT_MULTI_COMMIT_EN
  assign commit = wr_stb && ch_ok && (regsel == REG_CTRL) && writedata[COMMIT_BIT];
`else
  assign commit = 1'b0;
`endif

  assign tick = (ps_q == PS_W'(PRESCALE - 1));

  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n)  ps_q <= '0;
    else if (tick) ps_q <= '0;
    else           ps_q <= ps_q + 1'b1;

  for (genvar i = 0; i < CH_COUNT; i++) begin : g_ch
    ch_req_t req;
    assign req.we     = wr_stb && ch_ok && (ch_idx == ADDR_W'(i));
    assign req.regsel = regsel;
    assign req.wdata  = writedata;

    pio_out_channel #(.CH_WIDTH(CH_WIDTH)) u_ch (
      .clk     (clk),
      .reset_n (reset_n),
      .req     (req),
      .commit  (commit),
      .tick    (tick),
      .data_rd (data_rd[i]),
      .ctrl_rd (ctrl_rd[i]),
      .out     (ch_out[i])
    );
  end

  assign out_port = ch_out;

  always_comb begin
    readdata = '0;
    for (int i = 0; i < CH_COUNT; i++)
      if (ch_ok && (ch_idx == ADDR_W'(i)))
        case (regsel)
          REG_DATA: readdata[CH_WIDTH-1:0] = data_rd[i];
          REG_CTRL: readdata = ctrl_rd[i];
          default: ;
        endcase
  end

endmodule

// File: doc/pio_out_multi.md
Name: pio_out_multi

Overview:
- Parametrised Avalon-MM slave driving CH_COUNT independent output ports, each CH_WIDTH bits wide. Successor to the single-register display PIOs.
- Adds atomic set/clear access per channel and a per-channel hardware blink mode, timed by a shared prescaler (1 ms tick at 50 MHz by default).
- Sits between the Nios bus fabric and board outputs (7-seg digits, LED banks).

Parameters:
- CH_COUNT, 4, number of output channels (1..16)
- CH_WIDTH, 14, bits per channel (1..32)
- PRESCALE, 50000, clk cycles per blink tick (>=2)
- ADDR_W, $clog2(CH_COUNT)+2, localparam address width; not overridable

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous, active-low reset
- address  in  ADDR_W  bits [ADDR_W-1:2] select the channel, bits [1:0] select the register
- chipselect  in  1  slave select
- write_n  in  1  active-low write strobe
- writedata  in  32  write data
- readdata  out  32  read data, zero-extended, 0-cycle read latency (combinational)
- out_port  out  CH_COUNT*CH_WIDTH  flattened outputs; channel 0 occupies the LSBs

Behaviour:
- Write strobe: chipselect && !write_n. At most one register is written per cycle.
- Register offsets within a channel:
  - 0 DATA: write loads data = writedata[CH_WIDTH-1:0].
  - 1 OUTSET: data |= writedata[CH_WIDTH-1:0]. Reads return 0.
  - 2 OUTCLR: data &= ~writedata[CH_WIDTH-1:0]. Reads return 0.
  - 3 CTRL: bit0 blink_en, bits[15:8] period (in ticks). Reads return {16'b0, period, 7'b0, blink_en}.
- Channel index >= CH_COUNT: writes are ignored; reads return 0.
- Reset values: every data = 0, blink_en = 0, period = 0, phase = 0, blink counter = 0, prescaler = 0. Hence out_port = 0 and readdata = 0.
- Prescaler: counts 0..PRESCALE-1 and wraps. tick is a 1-cycle pulse in the cycle where count == PRESCALE-1.
- Per-channel blink counter, advanced only on tick while blink_en = 1:
  - Effective period is max(period, 1).
  - When counter == effective period - 1: phase toggles and counter resets to 0.
  - Otherwise the counter increments.
- Any write to CTRL clears that channel's counter and phase to 0 in the same cycle, overriding a coincident tick.
- Output per channel: blink_en && phase ? 0 : data. Muxing from registered state only.
- Latency: a write at clock edge N is visible on out_port after edge N, i.e. one cycle.
- Simultaneous DATA/OUTSET/OUTCLR write and tick: the data update and the phase update both take effect on the same edge.
- Clearing blink_en makes out_port equal data on the next cycle; phase is forced to 0.
- Reset asserted mid-blink: all state returns to reset values immediately (asynchronously). The prescaler restarts from 0 on release.

Optional Feature:
- Macro: PIO_OUT_MULTI_COMMIT_EN.
- Defined:
  - DATA/OUTSET/OUTCLR operate on a per-channel shadow register; reads of DATA return the shadow.
  - Writing CTRL with writedata[31] = 1 (at any channel's offset) copies all shadows to their data registers on that edge. That write leaves CTRL fields, counter and phase unmodified.
  - Shadows reset to 0.
  - Purpose: tear-free update of multi-digit displays.
- Undefined:
  - No shadow registers; DATA writes go straight to data.
  - writedata[31] on CTRL is ignored and reads as 0.

Decomposition:
- Package pio_out_pkg:
  - Register offsets REG_DATA = 0, REG_OUTSET = 1, REG_OUTCLR = 2, REG_CTRL = 3.
  - CTRL field positions: BLINK_EN_BIT = 0, PERIOD_LSB = 8, PERIOD_MSB = 15, COMMIT_BIT = 31.
- Sub-module pio_out_channel: owns one channel's data (plus shadow when the macro is defined), CTRL fields, blink counter, phase and output mux.
- Top level owns:
  - address decode
  - prescaler
  - read mux
  - generate loop over CH_COUNT instances of pio_out_channel

Test Plan:
- Reset, then write DATA ch0 = 0x3FFF and read it back -> out_port[13:0] = 0x3FFF one cycle after the write; readdata = 0x00003FFF; other channels remain 0.
- ch1 DATA = 0x00F0, then OUTSET 0x000F, then OUTCLR 0x0030 -> ch1 output = 0x00CF; reading OUTSET returns 0.
- PRESCALE = 4, ch2 DATA = 0x1234, CTRL = 0x0201 (period 2) -> output alternates between 0x1234 and 0 every 8 clk cycles; period 0 behaves as period 1 (toggle every 4 cycles).
- CTRL write landing on a tick cycle -> phase = 0, output = data, and the next toggle occurs a full period later. Clearing blink_en mid-phase -> output = data on the next cycle.
- Write to channel index CH_COUNT (CH_COUNT = 3, address 0xC) -> no output change, readdata = 0. Assert reset_n mid-blink -> out_port = 0 with no clk edge.
- With PIO_OUT_MULTI_COMMIT_EN: write DATA ch0 = 0x1, ch1 = 0x2 -> out_port unchanged. Then write CTRL ch3 = 0x80000000 -> both channels update on the same edge and ch3 blink settings are unchanged.
